// File: rtl/sobel_dir_seq.sv
`default_nettype none
// ============================================================================
// sobel_dir_seq : thresholds Sobel gradient pairs, divides |Y|*256 by |X| over
//                 17 cycles and quantises the quotient to a direction code.
// Revision      : 1.0
// ============================================================================
module sobel_dir_seq #(
  parameter int STARTADDRESS = 770,
  parameter int ENDADDRESS   = 523518,
  parameter int STHRESHOLD   = 5632,
  parameter int PIXW         = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startEn,
  input  logic            inValid,
  output logic            inReady,
  input  logic [8:0]      sobelX,
  input  logic [8:0]      sobelY,
  output logic            outValid,
  input  logic            outReady,
  output logic [7:0]      dirE,
  output logic [PIXW-1:0] pixelAddr,
  output logic            busy,
  output logic            done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_CLASS = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [PIXW-1:0]   c_start_addr = PIXW'(STARTADDRESS);
  localparam logic [PIXW-1:0]   c_end_addr   = PIXW'(ENDADDRESS);
  localparam logic [17:0]       c_thresh     = 18'(STHRESHOLD);
  localparam logic signed [17:0] c_q_lo      = 18'sd106;
  localparam logic signed [17:0] c_q_hi      = 18'sd616;
  localparam logic signed [17:0] c_q_neg     = -18'sd305;
  localparam logic [4:0]        c_last_bit   = 5'd16;

  logic [2:0]      r_state;
  logic [7:0]      r_dir;
  logic [PIXW-1:0] r_addr;
  logic [8:0]      r_divisor;
  logic [16:0]     r_dividend;
  logic [8:0]      r_rem;
  logic [16:0]     r_quot;
  logic [4:0]      r_cnt;
  logic            r_neg;

  logic [8:0]        w_absx;
  logic [8:0]        w_absy;
  logic [17:0]       w_x2;
  logic [17:0]       w_y2;
  logic [17:0]       w_mag;
  logic [9:0]        w_trial;
  logic              w_ge;
  logic [8:0]        w_sub;
  logic signed [17:0] w_q;
  logic [7:0]        w_class;

  // 9-bit magnitude keeps |-256| = 256 exact
  assign w_absx = sobelX[8] ? (~sobelX + 9'd1) : sobelX;
  assign w_absy = sobelY[8] ? (~sobelY + 9'd1) : sobelY;
  assign w_x2   = {9'd0, w_absx} * {9'd0, w_absx};
  assign w_y2   = {9'd0, w_absy} * {9'd0, w_absy};
  assign w_mag  = w_x2 + w_y2;

  // Remainder stays below the divisor, so the difference fits in 9 bits
  assign w_trial = {r_rem, r_dividend[16]};
  assign w_ge    = w_trial >= {1'b0, r_divisor};
  assign w_sub   = w_trial[8:0] - r_divisor;

  assign w_q = r_neg ? 18'(-{1'b0, r_quot}) : {1'b0, r_quot};

  always_comb begin
    w_class = 8'd45;
    if (w_q > c_q_lo && w_q <= c_q_hi)
      w_class = 8'd135;
    else if (w_q > c_q_hi || w_q <= c_q_neg)
      w_class = 8'd90;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dir      <= 8'd0;
      r_addr     <= '0;
      r_divisor  <= 9'd0;
      r_dividend <= 17'd0;
      r_rem      <= 9'd0;
      r_quot     <= 17'd0;
      r_cnt      <= 5'd0;
      r_neg      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startEn) begin
            r_addr  <= c_start_addr;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (inValid) begin
            r_divisor  <= w_absx;
            r_dividend <= {w_absy, 8'd0};
            r_rem      <= 9'd0;
            r_quot     <= 17'd0;
            r_cnt      <= 5'd0;
            r_neg      <= sobelX[8] ^ sobelY[8];
            if (sobelX == 9'd0) begin
              r_dir   <= 8'd0;
              r_state <= S_OUT;
            end else if (w_mag < c_thresh) begin
              r_dir   <= 8'd10;
              r_state <= S_OUT;
            end else begin
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem      <= w_ge ? w_sub : w_trial[8:0];
          r_quot     <= {r_quot[15:0], w_ge};
          r_dividend <= {r_dividend[15:0], 1'b0};
          r_cnt      <= r_cnt + 5'd1;
          if (r_cnt == c_last_bit)
            r_state <= S_CLASS;
        end
        S_CLASS: begin
          r_dir   <= w_class;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (outReady) begin
            if (r_addr == c_end_addr) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inReady   = (r_state == S_LOAD);
  assign outValid  = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dirE      = r_dir;
  assign pixelAddr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sobel_dir_seq.sv
`default_nettype none
// ============================================================================
// tb_sobel_dir_seq : directed vector bench for the Sobel direction sequencer.
// Revision         : 1.0
// ============================================================================
module tb_sobel_dir_seq;

  localparam int PIXW = 24;

  typedef struct {
    int x;
    int y;
    int dir;
    int lat;
    int bp;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            startEn;
  logic            inValid;
  logic            inReady;
  logic [8:0]      sobelX;
  logic [8:0]      sobelY;
  logic            outValid;
  logic            outReady;
  logic [7:0]      dirE;
  logic [PIXW-1:0] pixelAddr;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  sobel_dir_seq #(
    .STARTADDRESS(0),
    .ENDADDRESS  (3),
    .STHRESHOLD  (5632),
    .PIXW        (PIXW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .startEn  (startEn),
    .inValid  (inValid),
    .inReady  (inReady),
    .sobelX   (sobelX),
    .sobelY   (sobelY),
    .outValid (outValid),
    .outReady (outReady),
    .dirE     (dirE),
    .pixelAddr(pixelAddr),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    startEn = 1'b1;
    @(posedge clk);
    #1 startEn = 1'b0;
  endtask

  task automatic run_pixel(input int idx, input vec_t v);
    int  n;
    bit  seen;
    logic [7:0]      hold_dir;
    logic [PIXW-1:0] hold_addr;
    @(negedge clk);
    check($sformatf("v%0d_in_ready", idx), 32'(inReady), 32'd1);
    sobelX  = 9'(v.x);
    sobelY  = 9'(v.y);
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (outValid) seen = 1'b1;
      else check($sformatf("v%0d_in_ready_busy", idx), 32'(inReady), 32'd0);
    end
    check($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
    check($sformatf("v%0d_dirE", idx), 32'(dirE), 32'(v.dir));
    check($sformatf("v%0d_addr", idx), 32'(pixelAddr), 32'(idx % 4));
    hold_dir  = dirE;
    hold_addr = pixelAddr;
    for (int b = 0; b < v.bp; b++) begin
      @(negedge clk);
      check($sformatf("v%0d_bp_valid", idx), 32'(outValid), 32'd1);
      check($sformatf("v%0d_bp_ready", idx), 32'(inReady), 32'd0);
      check($sformatf("v%0d_bp_dirE", idx), 32'(dirE), 32'(hold_dir));
      check($sformatf("v%0d_bp_addr", idx), 32'(pixelAddr), 32'(hold_addr));
    end
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  task automatic run_frame(input int first);
    pulse_start();
    @(negedge clk);
    check("frame_busy", 32'(busy), 32'd1);
    check("frame_start_addr", 32'(pixelAddr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) check($sformatf("v%0d_no_done", first + k), 32'(done), 32'd0);
      run_pixel(first + k, vecs[first + k]);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_addr", 32'(pixelAddr), 32'd3);
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //            x     y    dir lat bp
    vecs[0]  = '{  10,   10,  10,  1, 0};
    vecs[1]  = '{   0,  100,   0,  1, 0};
    vecs[2]  = '{ 100,  100, 135, 19, 5};
    vecs[3]  = '{ 100,  -50,  45, 19, 0};
    vecs[4]  = '{ -60,  100,  90, 19, 0};
    vecs[5]  = '{-256, -256, 135, 19, 0};
    vecs[6]  = '{  75,    0,  10,  1, 0};
    vecs[7]  = '{  75,    3,  45, 19, 0};
    vecs[8]  = '{  32,   77, 135, 19, 0};
    vecs[9]  = '{  32,   78,  90, 19, 0};
    vecs[10] = '{-200,  239,  90, 19, 0};
    vecs[11] = '{-200,  238,  45, 19, 0};

    reset    = 1'b1;
    startEn  = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    sobelX   = 9'd0;
    sobelY   = 9'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(inReady), 32'd0);
    check("rst_out_valid", 32'(outValid), 32'd0);
    check("rst_dirE", 32'(dirE), 32'd0);
    check("rst_addr", 32'(pixelAddr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset   = 1'b0;
    startEn = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);

    run_frame(0);
    run_frame(4);
    run_frame(8);

    // Reset in the middle of a divide
    pulse_start();
    @(negedge clk);
    sobelX  = 9'd100;
    sobelY  = 9'd100;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(inReady), 32'd0);
    check("mid_rst_out_valid", 32'(outValid), 32'd0);
    check("mid_rst_dirE", 32'(dirE), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    inValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_in_ready", 32'(inReady), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    inValid = 1'b0;
    pulse_start();
    @(negedge clk);
    check("restart_in_ready", 32'(inReady), 32'd1);
    check("restart_addr", 32'(pixelAddr), 32'd0);
    run_pixel(0, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
